// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready payload with optional 2-entry skid buffer and flush-to-bubble.
// Optional macro PIPE_STAGE_STATS_EN adds stall_cnt/flush_cnt statistics outputs.
module pipe_stage_reg #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                SKID       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              m_valid_reg, m_valid_next;
    logic [DATA_W-1:0] m_data_reg,  m_data_next;
    logic              s_valid_reg, s_valid_next;
    logic [DATA_W-1:0] s_data_reg,  s_data_next;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid_reg & out_ready;

    generate
        if (SKID != 0) begin : gen_ready_skid
            // Ready depends only on the skid register, breaking the downstream ready path.
            assign in_ready = ~rst & ~s_valid_reg;
        end else begin : gen_ready_pass
            assign in_ready = ~rst & (~m_valid_reg | out_ready);
        end
    endgenerate

    always_comb begin
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        s_valid_next = s_valid_reg;
        s_data_next  = s_data_reg;
        if (flush) begin
            // Incoming entry is accepted but dropped along with everything held.
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
            m_data_next  = BUBBLE_VAL;
            s_data_next  = BUBBLE_VAL;
        end else if (SKID != 0) begin
            if (!m_valid_reg || out_fire) begin
                if (s_valid_reg) begin
                    m_valid_next = 1'b1;
                    m_data_next  = s_data_reg;
                    s_valid_next = in_fire;
                    if (in_fire) begin
                        s_data_next = in_data;
                    end
                end else if (in_fire) begin
                    m_valid_next = 1'b1;
                    m_data_next  = in_data;
                end else begin
                    m_valid_next = 1'b0;
                end
            end else if (in_fire) begin
                s_valid_next = 1'b1;
                s_data_next  = in_data;
            end
        end else begin
            if (in_fire) begin
                m_valid_next = 1'b1;
                m_data_next  = in_data;
            end else if (out_fire) begin
                m_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= BUBBLE_VAL;
            s_valid_reg <= 1'b0;
            s_data_reg  <= BUBBLE_VAL;
        end else begin
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
            s_valid_reg <= s_valid_next;
            s_data_reg  <= s_data_next;
        end
    end

    assign out_valid = m_valid_reg;
    assign out_data  = m_valid_reg ? m_data_reg : BUBBLE_VAL;
    assign occupancy = {1'b0, m_valid_reg} + {1'b0, s_valid_reg};

`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (m_valid_reg && !out_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
